// File: rtl/vdg_timing_pkg.sv
// Shared video timing constants (PAL defaults) and the counter width helper.
package vdg_timing_pkg;

    localparam int unsigned PAL_LINE_LEN    = 229;
    localparam int unsigned PAL_PULSE_START = 17;
    localparam int unsigned PAL_PULSE_END   = 229;
    localparam int unsigned PAL_FIELD_LINES = 312;
    localparam int unsigned PAL_VSYNC_LINES = 3;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter on the falling edge of nVCLK with enable, synchronous clear
// and a combinational next-count / wrap flag for zero-skew decoding upstream.
module wrap_counter
    import vdg_timing_pkg::*;
#(
    parameter int unsigned MODULUS = PAL_LINE_LEN,
    localparam int unsigned W = cnt_width(MODULUS)
) (
    input  logic         nVCLK,
    input  logic         RESET,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] next_c_o,
    output logic         wrap_c_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = (count_q == W'(MODULUS - 1));

    // Clear wins over enable, so a clear never reports a wrap.
    always_comb begin
        count_d  = count_q;
        wrap_c_o = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (at_max) begin
                count_d  = '0;
                wrap_c_o = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(negedge nVCLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign next_c_o = count_d;

endmodule

// File: rtl/vclk_line_timer.sv
// Line/field timer clocked on the falling edge of nVCLK. Vertical counting,
// FieldStart and VSync exist only when VCLK_LINE_TIMER_VERT_EN is defined.
module vclk_line_timer
    import vdg_timing_pkg::*;
#(
    parameter int unsigned LINE_LEN    = PAL_LINE_LEN,
    parameter int unsigned PULSE_START = PAL_PULSE_START,
    parameter int unsigned PULSE_END   = PAL_PULSE_END,
    parameter int unsigned FIELD_LINES = PAL_FIELD_LINES,
    parameter int unsigned VSYNC_LINES = PAL_VSYNC_LINES,
    localparam int unsigned HW = cnt_width(LINE_LEN),
    localparam int unsigned VW = cnt_width(FIELD_LINES)
) (
    input  logic          nVCLK,
    input  logic          RESET,
    input  logic          Enable,
    input  logic          LineRestart,
    output logic [HW-1:0] HCount,
    output logic [VW-1:0] VCount,
    output logic          HPulse,
    output logic          LineStart,
    output logic          FieldStart,
    output logic          VSync
);

    if (PULSE_START >= PULSE_END || PULSE_END > LINE_LEN || VSYNC_LINES > FIELD_LINES) begin : g_param_err
        $error("vclk_line_timer: inconsistent timing parameters");
    end

    logic [HW-1:0] h_next;
    logic          h_wrap;
    logic          hpulse_d, hpulse_q;
    logic          line_start_d, line_start_q;

    wrap_counter #(.MODULUS(LINE_LEN)) u_hcnt (
        .nVCLK    (nVCLK),
        .RESET    (RESET),
        .en_i     (Enable),
        .clr_i    (LineRestart),
        .count_o  (HCount),
        .next_c_o (h_next),
        .wrap_c_o (h_wrap)
    );

    // Decode from the next count so flags line up with the count they describe.
    assign hpulse_d     = (32'(h_next) >= PULSE_START) && (32'(h_next) < PULSE_END);
    assign line_start_d = LineRestart | h_wrap;

    always_ff @(negedge nVCLK or posedge RESET) begin
        if (RESET) begin
            hpulse_q     <= 1'b0;
            line_start_q <= 1'b0;
        end else begin
            hpulse_q     <= hpulse_d;
            line_start_q <= line_start_d;
        end
    end

    assign HPulse    = hpulse_q;
    assign LineStart = line_start_q;

`ifdef VCLK_LINE_TIMER_VERT_EN
    logic [VW-1:0] v_next;
    logic          v_wrap;
    logic          field_start_d, field_start_q;
    logic          vsync_d, vsync_q;

    wrap_counter #(.MODULUS(FIELD_LINES)) u_vcnt (
        .nVCLK    (nVCLK),
        .RESET    (RESET),
        .en_i     (h_wrap),
        .clr_i    (1'b0),
        .count_o  (VCount),
        .next_c_o (v_next),
        .wrap_c_o (v_wrap)
    );

    // A restart leaves VCount alone, so it opens a field only on line 0.
    assign field_start_d = h_wrap ? v_wrap : (LineRestart && (VCount == '0));
    assign vsync_d       = (32'(v_next) < VSYNC_LINES);

    always_ff @(negedge nVCLK or posedge RESET) begin
        if (RESET) begin
            field_start_q <= 1'b0;
            vsync_q       <= (VSYNC_LINES > 0);
        end else begin
            field_start_q <= field_start_d;
            vsync_q       <= vsync_d;
        end
    end

    assign FieldStart = field_start_q;
    assign VSync      = vsync_q;
`else
    assign VCount     = '0;
    assign FieldStart = 1'b0;
    assign VSync      = 1'b0;
`endif

endmodule

// File: tb/tb_vclk_line_timer.sv
// Scoreboard bench for vclk_line_timer with default PAL parameters; covers
// both builds depending on VCLK_LINE_TIMER_VERT_EN.
module tb_vclk_line_timer;

    localparam int LL = 229;
    localparam int PS = 17;
    localparam int PE = 229;
    localparam int FL = 312;
    localparam int VS = 3;
    localparam int HW = 8;
    localparam int VW = 9;
`ifdef VCLK_LINE_TIMER_VERT_EN
    localparam bit VERT = 1'b1;
`else
    localparam bit VERT = 1'b0;
`endif

    logic          nVCLK;
    logic          RESET;
    logic          Enable;
    logic          LineRestart;
    logic [HW-1:0] HCount;
    logic [VW-1:0] VCount;
    logic          HPulse;
    logic          LineStart;
    logic          FieldStart;
    logic          VSync;

    vclk_line_timer dut (
        .nVCLK       (nVCLK),
        .RESET       (RESET),
        .Enable      (Enable),
        .LineRestart (LineRestart),
        .HCount      (HCount),
        .VCount      (VCount),
        .HPulse      (HPulse),
        .LineStart   (LineStart),
        .FieldStart  (FieldStart),
        .VSync       (VSync)
    );

    initial nVCLK = 1'b1;
    always #5 nVCLK = ~nVCLK;

    typedef struct {
        int h;
        int v;
        int hp;
        int ls;
        int fs;
        int vs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_h = 0;
    int   m_v = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one edge worth of inputs, predict the result, then compare.
    task automatic step(input bit en, input bit lr);
        exp_t e;
        int   nh;
        int   nv;
        int   ls;
        @(posedge nVCLK);
        Enable      = en;
        LineRestart = lr;
        nh = m_h;
        nv = m_v;
        ls = 0;
        if (lr) begin
            nh = 0;
            ls = 1;
        end else if (en) begin
            if (m_h == LL - 1) begin
                nh = 0;
                ls = 1;
                nv = (m_v == FL - 1) ? 0 : m_v + 1;
            end else begin
                nh = m_h + 1;
            end
        end
        m_h  = nh;
        m_v  = nv;
        e.h  = nh;
        e.v  = VERT ? nv : 0;
        e.hp = (nh >= PS && nh < PE) ? 1 : 0;
        e.ls = ls;
        e.fs = (VERT && ls == 1 && nv == 0) ? 1 : 0;
        e.vs = (VERT && nv < VS) ? 1 : 0;
        sb.push_back(e);
        @(negedge nVCLK);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check_eq("HCount", int'(HCount), e.h);
            check_eq("VCount", int'(VCount), e.v);
            check_eq("HPulse", int'(HPulse), e.hp);
            check_eq("LineStart", int'(LineStart), e.ls);
            check_eq("FieldStart", int'(FieldStart), e.fs);
            check_eq("VSync", int'(VSync), e.vs);
        end
    endtask

    // Reset is raised between edges and checked before the next falling edge.
    task automatic do_reset();
        @(posedge nVCLK);
        #1;
        RESET       = 1'b1;
        Enable      = 1'b0;
        LineRestart = 1'b0;
        #2;
        check_eq("rst_HCount", int'(HCount), 0);
        check_eq("rst_VCount", int'(VCount), 0);
        check_eq("rst_HPulse", int'(HPulse), 0);
        check_eq("rst_LineStart", int'(LineStart), 0);
        check_eq("rst_FieldStart", int'(FieldStart), 0);
        check_eq("rst_VSync", int'(VSync), VERT ? 1 : 0);
        @(posedge nVCLK);
        #1;
        RESET = 1'b0;
        m_h   = 0;
        m_v   = 0;
        sb.delete();
    endtask

    task automatic run_to(input int h, input int v, input int limit);
        int n;
        n = 0;
        while (!(m_h == h && (v < 0 || m_v == v)) && n < limit) begin
            step(1'b1, 1'b0);
            n++;
        end
        if (n >= limit) check_eq("run_to_timeout", n, -1);
    endtask

    initial begin
        int prev_hp;
        int last_ls;
        int rises;
        int fs_count;
        int vs_lines;
        int vert_any;

        RESET       = 1'b1;
        Enable      = 1'b0;
        LineRestart = 1'b0;
        repeat (2) @(negedge nVCLK);
        do_reset();

        // Two full lines after reset: pulse edges and line period.
        step(1'b1, 1'b0);
        check_eq("first_edge_h", int'(HCount), 1);
        prev_hp = 0;
        last_ls = -1;
        rises   = 0;
        for (int i = 1; i < 2 * LL + 1; i++) begin
            step(1'b1, 1'b0);
            if (HPulse && prev_hp == 0) begin
                rises++;
                check_eq("hp_rise_at", int'(HCount), PS);
            end
            if (!HPulse && prev_hp == 1) check_eq("hp_fall_at", int'(HCount), 0);
            if (LineStart) begin
                if (last_ls >= 0) check_eq("line_period", i - last_ls, LL);
                last_ls = i;
            end
            prev_hp = int'(HPulse);
        end
        check_eq("hp_rises", rises, 2);

        // Hold for five edges at HCount=100.
        run_to(100, -1, 2 * LL);
        repeat (5) step(1'b0, 1'b0);
        check_eq("hold_h", int'(HCount), 100);
        check_eq("hold_hp", int'(HPulse), 1);
        step(1'b1, 1'b0);
        check_eq("resume_h", int'(HCount), 101);

        // Restart on the last count of line 5 beats the wrap.
        run_to(LL - 1, VERT ? 5 : -1, 8 * LL);
        step(1'b0, 1'b1);
        check_eq("lr_h", int'(HCount), 0);
        check_eq("lr_ls", int'(LineStart), 1);
`ifdef VCLK_LINE_TIMER_VERT_EN
        check_eq("lr_v", int'(VCount), 5);
`endif
        step(1'b1, 1'b0);
        check_eq("lr_ls_drop", int'(LineStart), 0);

        // Random enable/restart mix.
        vert_any = 0;
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            if (VCount != '0 || VSync || FieldStart) vert_any = 1;
        end
`ifndef VCLK_LINE_TIMER_VERT_EN
        check_eq("vert_tied", vert_any, 0);
`endif

`ifdef VCLK_LINE_TIMER_VERT_EN
        // One full field from reset.
        do_reset();
        fs_count = 0;
        vs_lines = 0;
        for (int i = 0; i < FL * LL; i++) begin
            step(1'b1, 1'b0);
            if (FieldStart) fs_count++;
            if (LineStart && VSync) vs_lines++;
        end
        check_eq("fs_count", fs_count, 1);
        check_eq("fs_at_wrap", int'(FieldStart), 1);
        check_eq("field_end_v", int'(VCount), 0);
        check_eq("vs_lines", vs_lines, VS);
`endif

        // Asynchronous reset mid-line, then a clean restart.
        run_to(150, -1, 2 * LL);
        check_eq("pre_rst_h", int'(HCount), 150);
        do_reset();
        step(1'b1, 1'b0);
        check_eq("post_rst_h", int'(HCount), 1);
        check_eq("post_rst_ls", int'(LineStart), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
